// File: rtl/sd_spi_responder.sv
// sd_spi_responder: card end of an SD SPI-mode link. Oversamples SCLK/CS/MOSI
// in the CLK50 domain, decodes 48-bit command frames, models a minimal card
// initialisation (CMD0, CMD8, CMD55/ACMD41, CMD58) and shifts R1/R3/R7
// responses out on MISO after NCR_BYTES filler bytes.
// Build option: define SD_RESP_CRC_EN to check the CRC7 field of each command;
// a bad CRC still strobes CMD_STB but only returns R1 with the CRC-error bit.
//
// state | meaning
// HUNT  | waiting for a start bit (MOSI=0) on a byte boundary
// CMD   | shifting in the remaining 47 frame bits
// NCR   | MISO held high for NCR_BYTES filler bytes
// RESP  | shifting the response bytes out on falling SCLK edges
module sd_spi_responder #(
   parameter int unsigned INIT_POLLS = 2,
   parameter int unsigned NCR_BYTES  = 1,
   parameter logic [31:0] OCR        = 32'hC0FF8000
) (
   input  logic        clk50_i,
   input  logic        rst_i,
   input  logic        sclk_i,
   input  logic        cs_i,
   input  logic        mosi_i,
   output logic        miso_o,
   output logic        cmd_stb_o,
   output logic [5:0]  cmd_idx_o,
   output logic [31:0] cmd_arg_o,
   output logic        idle_o
);

   typedef enum logic [1:0] {HUNT, CMD, NCR, RESP} state_t;

   localparam logic [7:0] POLL_MAX = 8'(INIT_POLLS);
   localparam logic [3:0] NCR_N    = 4'(NCR_BYTES);

   logic [1:0]  sclk_sync_q, cs_sync_q, mosi_sync_q;
   logic        sclk_dly_q;
   logic [2:0]  bit_cnt_q;
   state_t      state_q;
   logic [46:0] sh_q;
   logic [5:0]  frm_cnt_q;
   logic [3:0]  ncr_cnt_q;
   logic [39:0] resp_q;
   logic [5:0]  rbits_q;
   logic        miso_q, cmd_stb_q, idle_q, app_q;
   logic [5:0]  cmd_idx_q;
   logic [31:0] cmd_arg_q;
   logic [7:0]  poll_q;

   logic        sclk_s, cs_s, mosi_s, rise_w, fall_w;
   logic [47:0] frame_w;
   logic [5:0]  idx_w;
   logic [31:0] arg_w;
   logic        crc_bad_w;
   logic        idle_d, app_d;
   logic [7:0]  poll_d, r1_d;
   logic [39:0] resp_d;
   logic [5:0]  rbits_d;

   assign sclk_s  = sclk_sync_q[1];
   assign cs_s    = cs_sync_q[1];
   assign mosi_s  = mosi_sync_q[1];
   assign rise_w  = sclk_s & ~sclk_dly_q;
   assign fall_w  = ~sclk_s & sclk_dly_q;
   assign frame_w = {sh_q, mosi_s};
   assign idx_w   = frame_w[45:40];
   assign arg_w   = frame_w[39:8];

`ifdef SD_RESP_CRC_EN
   function automatic logic [6:0] crc7(input logic [39:0] d);
      logic [6:0] c;
      logic       fb;
      c = '0;
      for (int i = 39; i >= 0; i--) begin
         fb = d[i] ^ c[6];
         c  = {c[5:0], 1'b0};
         if (fb) c = c ^ 7'h09;
      end
      return c;
   endfunction
   assign crc_bad_w = (crc7(frame_w[47:8]) != frame_w[7:1]);
   logic unused_ok;
   assign unused_ok = frame_w[47];
`else
   assign crc_bad_w = 1'b0;
   logic unused_ok;
   assign unused_ok = ^{frame_w[47], frame_w[7:1]};
`endif

   // Two-flop synchronisers plus one delayed SCLK copy for edge detection
   always_ff @(posedge clk50_i or posedge rst_i) begin
      if (rst_i) begin
         sclk_sync_q <= 2'b00;
         cs_sync_q   <= 2'b11;
         mosi_sync_q <= 2'b11;
         sclk_dly_q  <= 1'b0;
      end else begin
         sclk_sync_q <= {sclk_sync_q[0], sclk_i};
         cs_sync_q   <= {cs_sync_q[0], cs_i};
         mosi_sync_q <= {mosi_sync_q[0], mosi_i};
         sclk_dly_q  <= sclk_s;
      end
   end

   // Bit-within-byte counter; zero marks a byte boundary
   always_ff @(posedge clk50_i or posedge rst_i) begin
      if (rst_i)       bit_cnt_q <= 3'd0;
      else if (cs_s)   bit_cnt_q <= 3'd0;
      else if (rise_w) bit_cnt_q <= bit_cnt_q + 3'd1;
   end

   // Command decode and card model update for the frame completing this cycle
   always_comb begin
      idle_d  = idle_q;
      app_d   = 1'b0;
      poll_d  = poll_q;
      r1_d    = 8'h00;
      rbits_d = 6'd7;
      if (crc_bad_w) begin
         r1_d[3] = 1'b1;
      end else begin
         case (idx_w)
            6'd0: begin
               idle_d = 1'b1;
               poll_d = 8'd0;
            end
            6'd8:  rbits_d = 6'd39;
            6'd55: app_d = 1'b1;
            6'd41: begin
               if (!app_q)                 r1_d[2] = 1'b1;
               else if (poll_q < POLL_MAX) poll_d  = poll_q + 8'd1;
               else                        idle_d  = 1'b0;
            end
            6'd58:   rbits_d = 6'd39;
            default: r1_d[2] = 1'b1;
         endcase
      end
      r1_d[0] = idle_d;
      resp_d  = {r1_d, 32'h0};
      if (!crc_bad_w && idx_w == 6'd8)
         resp_d = {r1_d, 16'h0000, 4'h0, arg_w[11:8], arg_w[7:0]};
      if (!crc_bad_w && idx_w == 6'd58)
         resp_d = {r1_d, ~idle_d, OCR[30:0]};
   end

   // Frame/response FSM; CS high overrides everything and keeps card state
   always_ff @(posedge clk50_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= HUNT;
         sh_q      <= '0;
         frm_cnt_q <= 6'd0;
         ncr_cnt_q <= 4'd0;
         resp_q    <= '0;
         rbits_q   <= 6'd0;
         miso_q    <= 1'b1;
         cmd_stb_q <= 1'b0;
         cmd_idx_q <= 6'd0;
         cmd_arg_q <= 32'd0;
         idle_q    <= 1'b1;
         app_q     <= 1'b0;
         poll_q    <= 8'd0;
      end else begin
         cmd_stb_q <= 1'b0;
         if (cs_s) begin
            state_q <= HUNT;
            miso_q  <= 1'b1;
         end else begin
            case (state_q)
               HUNT: if (rise_w && bit_cnt_q == 3'd0 && !mosi_s) begin
                  state_q   <= CMD;
                  sh_q      <= '0;
                  frm_cnt_q <= 6'd1;
               end
               CMD: if (rise_w) begin
                  sh_q <= frame_w[46:0];
                  if (frm_cnt_q == 6'd47) begin
                     if (frame_w[46] && frame_w[0]) begin
                        cmd_stb_q <= 1'b1;
                        cmd_idx_q <= idx_w;
                        cmd_arg_q <= arg_w;
                        idle_q    <= idle_d;
                        app_q     <= app_d;
                        poll_q    <= poll_d;
                        resp_q    <= resp_d;
                        rbits_q   <= rbits_d;
                        ncr_cnt_q <= 4'd0;
                        state_q   <= NCR;
                     end else begin
                        state_q <= HUNT;
                     end
                  end else begin
                     frm_cnt_q <= frm_cnt_q + 6'd1;
                  end
               end
               NCR: begin
                  if (rise_w && bit_cnt_q == 3'd7) begin
                     ncr_cnt_q <= ncr_cnt_q + 4'd1;
                  end else if (fall_w && bit_cnt_q == 3'd0 && ncr_cnt_q == NCR_N) begin
                     state_q <= RESP;
                     miso_q  <= resp_q[39];
                     resp_q  <= {resp_q[38:0], 1'b0};
                  end
               end
               RESP: if (fall_w) begin
                  if (rbits_q == 6'd0) begin
                     state_q <= HUNT;
                     miso_q  <= 1'b1;
                  end else begin
                     miso_q  <= resp_q[39];
                     resp_q  <= {resp_q[38:0], 1'b0};
                     rbits_q <= rbits_q - 6'd1;
                  end
               end
               default: state_q <= HUNT;
            endcase
         end
      end
   end

   assign miso_o    = miso_q;
   assign cmd_stb_o = cmd_stb_q;
   assign cmd_idx_o = cmd_idx_q;
   assign cmd_arg_o = cmd_arg_q;
   assign idle_o    = idle_q;

endmodule

// File: tb/tb_sd_spi_responder.sv
// Directed bench for sd_spi_responder: a command/response table plus
// hand-written sequences for CS abort, CS racing the end bit, bad framing
// and the CRC field.
module tb_sd_spi_responder;

   localparam int HALF = 6;
   localparam int NCR  = 1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sclk = 1'b0;
   logic        cs = 1'b1;
   logic        mosi = 1'b1;
   logic        miso, cmd_stb, idle;
   logic [5:0]  cmd_idx;
   logic [31:0] cmd_arg;

   int n_checks = 0;
   int n_fail   = 0;
   int stb_cycles = 0;

   sd_spi_responder #(.INIT_POLLS(2), .NCR_BYTES(NCR), .OCR(32'hC0FF8000)) dut (
      .clk50_i  (clk),
      .rst_i    (rst),
      .sclk_i   (sclk),
      .cs_i     (cs),
      .mosi_i   (mosi),
      .miso_o   (miso),
      .cmd_stb_o(cmd_stb),
      .cmd_idx_o(cmd_idx),
      .cmd_arg_o(cmd_arg),
      .idle_o   (idle)
   );

   always #10 clk = ~clk;

   always @(posedge clk) if (cmd_stb) stb_cycles <= stb_cycles + 1;

   typedef struct {
      logic [5:0]  idx;
      logic [31:0] arg;
      int          len;
      logic [39:0] exp;
      logic        idle;
   } vec_t;

   vec_t vecs [18];

   task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [6:0] crc7(input logic [39:0] d);
      logic [6:0] c;
      logic       fb;
      c = '0;
      for (int i = 39; i >= 0; i--) begin
         fb = d[i] ^ c[6];
         c  = {c[5:0], 1'b0};
         if (fb) c = c ^ 7'h09;
      end
      return c;
   endfunction

   function automatic logic [47:0] mk_frame(input logic [5:0] idx, input logic [31:0] arg);
      logic [39:0] h;
      h = {2'b01, idx, arg};
      return {h, crc7(h), 1'b1};
   endfunction

   task automatic spi_bit(input logic b, output logic r);
      mosi = b;
      repeat (HALF) @(negedge clk);
      r = miso;
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
   endtask

   task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
      logic r;
      for (int i = 7; i >= 0; i--) begin
         spi_bit(tx[i], r);
         rx[i] = r;
      end
   endtask

   task automatic send_frame(input logic [47:0] f);
      logic r;
      for (int i = 47; i >= 0; i--) spi_bit(f[i], r);
   endtask

   task automatic set_vec(input int i, input logic [5:0] idx, input logic [31:0] arg,
                          input int len, input logic [39:0] exp, input logic idl);
      vecs[i].idx  = idx;
      vecs[i].arg  = arg;
      vecs[i].len  = len;
      vecs[i].exp  = exp;
      vecs[i].idle = idl;
   endtask

   // Sends a frame, checks filler bytes, response bytes and one trailing idle byte
   task automatic run_cmd(input string tag, input logic [47:0] f, input int len, input logic [39:0] exp);
      logic [7:0] rx;
      send_frame(f);
      for (int b = 0; b < NCR; b++) begin
         spi_byte(8'hFF, rx);
         check($sformatf("%s filler", tag), {32'h0, rx}, 40'hFF);
      end
      for (int b = 0; b < len; b++) begin
         spi_byte(8'hFF, rx);
         check($sformatf("%s byte%0d", tag, b), {32'h0, rx}, {32'h0, exp[39-8*b -: 8]});
      end
      spi_byte(8'hFF, rx);
      check($sformatf("%s tail", tag), {32'h0, rx}, 40'hFF);
   endtask

   initial begin
      int          stb0;
      logic [7:0]  rx;
      logic [47:0] f;
      logic        r;

      set_vec(0,  6'd0,  32'h0000_0000, 1, 40'h01_00000000, 1'b1);
      set_vec(1,  6'd8,  32'h0000_01AA, 5, 40'h01_000001AA, 1'b1);
      set_vec(2,  6'd17, 32'h0000_0000, 1, 40'h05_00000000, 1'b1);
      set_vec(3,  6'd41, 32'h4000_0000, 1, 40'h05_00000000, 1'b1);
      set_vec(4,  6'd58, 32'h0000_0000, 5, 40'h01_40FF8000, 1'b1);
      set_vec(5,  6'd55, 32'h0000_0000, 1, 40'h01_00000000, 1'b1);
      set_vec(6,  6'd41, 32'h4000_0000, 1, 40'h01_00000000, 1'b1);
      set_vec(7,  6'd55, 32'h0000_0000, 1, 40'h01_00000000, 1'b1);
      set_vec(8,  6'd17, 32'h0000_0200, 1, 40'h05_00000000, 1'b1);
      set_vec(9,  6'd41, 32'h4000_0000, 1, 40'h05_00000000, 1'b1);
      set_vec(10, 6'd55, 32'h0000_0000, 1, 40'h01_00000000, 1'b1);
      set_vec(11, 6'd41, 32'h4000_0000, 1, 40'h01_00000000, 1'b1);
      set_vec(12, 6'd55, 32'h0000_0000, 1, 40'h01_00000000, 1'b1);
      set_vec(13, 6'd41, 32'h4000_0000, 1, 40'h00_00000000, 1'b0);
      set_vec(14, 6'd58, 32'h0000_0000, 5, 40'h00_C0FF8000, 1'b0);
      set_vec(15, 6'd17, 32'h0000_0000, 1, 40'h04_00000000, 1'b0);
      set_vec(16, 6'd8,  32'h0000_0ABC, 5, 40'h00_00000ABC, 1'b0);
      set_vec(17, 6'd0,  32'h0000_0000, 1, 40'h01_00000000, 1'b1);

      repeat (4) @(negedge clk);
      check("reset miso", {39'h0, miso}, 40'h1);
      check("reset stb", {39'h0, cmd_stb}, 40'h0);
      check("reset idx", {34'h0, cmd_idx}, 40'h0);
      check("reset arg", {8'h0, cmd_arg}, 40'h0);
      check("reset idle", {39'h0, idle}, 40'h1);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      cs = 1'b0;
      repeat (8) @(negedge clk);

      for (int i = 0; i < 18; i++) begin
         stb0 = stb_cycles;
         run_cmd($sformatf("v%0d cmd%0d", i, vecs[i].idx), mk_frame(vecs[i].idx, vecs[i].arg),
                 vecs[i].len, vecs[i].exp);
         check($sformatf("v%0d stb", i), 40'(stb_cycles - stb0), 40'd1);
         check($sformatf("v%0d idx", i), {34'h0, cmd_idx}, {34'h0, vecs[i].idx});
         check($sformatf("v%0d arg", i), {8'h0, cmd_arg}, {8'h0, vecs[i].arg});
         check($sformatf("v%0d idle", i), {39'h0, idle}, {39'h0, vecs[i].idle});
      end

      // CS raised in the middle of a CMD8 response
      send_frame(mk_frame(6'd8, 32'h0000_01AA));
      spi_byte(8'hFF, rx);
      spi_byte(8'hFF, rx);
      spi_byte(8'hFF, rx);
      check("abort second byte", {32'h0, rx}, 40'h00);
      cs = 1'b1;
      repeat (8) @(negedge clk);
      check("abort miso cs high", {39'h0, miso}, 40'h1);
      spi_byte(8'hFF, rx);
      check("abort miso clocked", {32'h0, rx}, 40'hFF);
      check("abort idle kept", {39'h0, idle}, 40'h1);
      cs = 1'b0;
      repeat (8) @(negedge clk);
      stb0 = stb_cycles;
      run_cmd("after abort cmd0", mk_frame(6'd0, 32'h0), 1, 40'h01_00000000);
      check("after abort stb", 40'(stb_cycles - stb0), 40'd1);

      // CS rises together with the final SCLK rise: frame must be dropped
      stb0 = stb_cycles;
      f = mk_frame(6'd17, 32'h0000_1234);
      for (int i = 47; i >= 1; i--) spi_bit(f[i], r);
      mosi = f[0];
      repeat (HALF) @(negedge clk);
      sclk = 1'b1;
      cs   = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
      repeat (2 * HALF) @(negedge clk);
      check("race stb", 40'(stb_cycles - stb0), 40'd0);
      check("race idx", {34'h0, cmd_idx}, 40'h0);
      check("race miso", {39'h0, miso}, 40'h1);
      cs = 1'b0;
      repeat (8) @(negedge clk);

      // Bad framing: end bit 0, then transmission bit 0
      stb0 = stb_cycles;
      f = mk_frame(6'd17, 32'h0);
      f[0] = 1'b0;
      send_frame(f);
      spi_byte(8'hFF, rx);
      check("no end bit resp", {32'h0, rx}, 40'hFF);
      spi_byte(8'hFF, rx);
      check("no end bit resp2", {32'h0, rx}, 40'hFF);
      f = mk_frame(6'd17, 32'h0);
      f[46] = 1'b0;
      send_frame(f);
      spi_byte(8'hFF, rx);
      check("no tx bit resp", {32'h0, rx}, 40'hFF);
      spi_byte(8'hFF, rx);
      check("no tx bit resp2", {32'h0, rx}, 40'hFF);
      check("bad frame stb", 40'(stb_cycles - stb0), 40'd0);
      check("bad frame idx", {34'h0, cmd_idx}, 40'h0);

      // CMD0 with a zero CRC byte
      stb0 = stb_cycles;
      f = mk_frame(6'd0, 32'h0);
      f[7:0] = 8'h01;
`ifdef SD_RESP_CRC_EN
      run_cmd("crc cmd0", f, 1, 40'h09_00000000);
`else
      run_cmd("crc cmd0", f, 1, 40'h01_00000000);
`endif
      check("crc stb", 40'(stb_cycles - stb0), 40'd1);
      check("crc idle", {39'h0, idle}, 40'h1);

      cs = 1'b1;
      repeat (8) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
